// File: rtl/lan_led_status_if.sv
// ============================================================================
//  Module      : lan_led_status_if
//  Description : LAN LED pin inputs, LinkChg write port and status outputs
//                of lan_led_status, bundled with master/slave modports.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface lan_led_status_if #(
    parameter int NPORT = 2
);
    logic [NPORT-1:0]   PActivity;
    logic [NPORT-1:0]   Speed1P;
    logic [NPORT-1:0]   Speed2P;
    logic               RegWr;
    logic [NPORT-1:0]   RegWrData;
    logic [2*NPORT-1:0] LinkSpeed;
    logic [NPORT-1:0]   ActStretch;
    logic [NPORT-1:0]   LinkChg;
    logic               LanIrq;

    modport master (
        output PActivity, Speed1P, Speed2P, RegWr, RegWrData,
        input  LinkSpeed, ActStretch, LinkChg, LanIrq
    );

    modport slave (
        input  PActivity, Speed1P, Speed2P, RegWr, RegWrData,
        output LinkSpeed, ActStretch, LinkChg, LanIrq
    );
endinterface

`default_nettype wire

// File: rtl/lan_led_status.sv
// ============================================================================
//  Module      : lan_led_status
//  Description : Synchronises/debounces LAN controller LED pins, decodes link
//                speed, stretches activity and keeps sticky W1C link-change
//                flags. Optional interrupt flop: LAN_LED_STATUS_IRQ_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module lan_led_status #(
    parameter int NPORT       = 2,
    parameter int DEB_CNT     = 3,
    parameter int STRETCH_CNT = 1638,
    parameter int SCW         = 11
) (
    input  logic             CLK32768,
    input  logic             RST_N,
    input  logic             ALL_PWRGD,
    lan_led_status_if.slave  bus
);

    localparam int              c_dw       = 4;
    localparam logic [c_dw-1:0] c_deb_last = c_dw'(DEB_CNT - 1);
    localparam logic [SCW-1:0]  c_stretch  = SCW'(STRETCH_CNT);

    logic [NPORT-1:0] r_act_s1, r_act_s2, r_act_d;
    logic [NPORT-1:0] r_sp1_s1, r_sp1_s2;
    logic [NPORT-1:0] r_sp2_s1, r_sp2_s2;
    logic [NPORT-1:0] w_commit;
    logic [NPORT-1:0] w_wr_clr;
    logic [NPORT-1:0] w_chg_next;
    logic [NPORT-1:0] r_chg;

    // Idle level of every pin is 1, so power-bad parks the chain as if idle.
    always_ff @(posedge CLK32768 or negedge RST_N) begin
        if (!RST_N) begin
            r_act_s1 <= '1;
            r_act_s2 <= '1;
            r_act_d  <= '1;
            r_sp1_s1 <= '1;
            r_sp1_s2 <= '1;
            r_sp2_s1 <= '1;
            r_sp2_s2 <= '1;
        end else if (!ALL_PWRGD) begin
            r_act_s1 <= '1;
            r_act_s2 <= '1;
            r_act_d  <= '1;
            r_sp1_s1 <= '1;
            r_sp1_s2 <= '1;
            r_sp2_s1 <= '1;
            r_sp2_s2 <= '1;
        end else begin
            r_act_s1 <= bus.PActivity;
            r_act_s2 <= r_act_s1;
            r_act_d  <= r_act_s2;
            r_sp1_s1 <= bus.Speed1P;
            r_sp1_s2 <= r_sp1_s1;
            r_sp2_s1 <= bus.Speed2P;
            r_sp2_s2 <= r_sp2_s1;
        end
    end

    generate
        for (genvar gi = 0; gi < NPORT; gi++) begin : g_port
            logic [1:0]      w_code;
            logic [1:0]      r_cand;
            logic [1:0]      r_com;
            logic [c_dw-1:0] r_cnt;
            logic [c_dw-1:0] w_run;
            logic [c_dw-1:0] w_cnt_next;
            logic [SCW-1:0]  r_str;
            logic [SCW-1:0]  w_str_next;
            logic            r_act_out;
            logic            w_fell;
            logic            w_drop;

            // Pins are active-low, so the speed code is the inverted pair.
            assign w_code = ~{r_sp1_s2[gi], r_sp2_s2[gi]};

            // w_run = matching samples already seen before this one.
            assign w_run        = (w_code == r_cand) ? r_cnt + c_dw'(1) : '0;
            assign w_commit[gi] = (w_code != r_com) && (w_run == c_deb_last);
            assign w_fell       = r_act_d[gi] & ~r_act_s2[gi];
            assign w_drop       = w_commit[gi] && (w_code == 2'b00);

            always_comb begin
                w_cnt_next = r_cnt;
                if (w_commit[gi] || (w_code != r_cand)) begin
                    w_cnt_next = '0;
                end else if (r_cand != r_com) begin
                    w_cnt_next = w_run;
                end
            end

            always_comb begin
                w_str_next = r_str;
                if (w_drop) begin
                    w_str_next = '0;
                end else if (w_fell && (r_com != 2'b00)) begin
                    w_str_next = c_stretch;
                end else if (r_str != '0) begin
                    w_str_next = r_str - SCW'(1);
                end
            end

            always_ff @(posedge CLK32768 or negedge RST_N) begin
                if (!RST_N) begin
                    r_cand    <= 2'b00;
                    r_com     <= 2'b00;
                    r_cnt     <= '0;
                    r_str     <= '0;
                    r_act_out <= 1'b0;
                end else if (!ALL_PWRGD) begin
                    r_cand    <= 2'b00;
                    r_com     <= 2'b00;
                    r_cnt     <= '0;
                    r_str     <= '0;
                    r_act_out <= 1'b0;
                end else begin
                    r_cand    <= w_code;
                    r_cnt     <= w_cnt_next;
                    r_str     <= w_str_next;
                    r_act_out <= (w_str_next != '0);
                    if (w_commit[gi]) begin
                        r_com <= w_code;
                    end
                end
            end

            assign bus.LinkSpeed[2*gi +: 2] = r_com;
            assign bus.ActStretch[gi]       = r_act_out;
        end
    endgenerate

    // A commit on the same edge as a clear keeps the flag set.
    assign w_wr_clr   = bus.RegWr ? bus.RegWrData : '0;
    assign w_chg_next = (r_chg & ~w_wr_clr) | w_commit;

    always_ff @(posedge CLK32768 or negedge RST_N) begin
        if (!RST_N) begin
            r_chg <= '0;
        end else if (!ALL_PWRGD) begin
            r_chg <= '0;
        end else begin
            r_chg <= w_chg_next;
        end
    end

    assign bus.LinkChg = r_chg;

`ifdef LAN_LED_STATUS_IRQ_EN
    logic r_irq;

    always_ff @(posedge CLK32768 or negedge RST_N) begin
        if (!RST_N) begin
            r_irq <= 1'b0;
        end else if (!ALL_PWRGD) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |w_chg_next;
        end
    end

    assign bus.LanIrq = r_irq;
`else
    assign bus.LanIrq = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lan_led_status.sv
// ============================================================================
//  Module      : tb_lan_led_status
//  Description : Randomised self-checking bench for lan_led_status against a
//                time-based behavioural model of the pin-to-status rules.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_lan_led_status;

    localparam int NPORT       = 2;
    localparam int DEB_CNT     = 3;
    localparam int STRETCH_CNT = 8;
    localparam int SCW         = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic pwrgd = 1'b0;

    int checks   = 0;
    int failures = 0;

    lan_led_status_if #(.NPORT(NPORT)) bus ();

    lan_led_status #(
        .NPORT       (NPORT),
        .DEB_CNT     (DEB_CNT),
        .STRETCH_CNT (STRETCH_CNT),
        .SCW         (SCW)
    ) dut (
        .CLK32768  (clk),
        .RST_N     (rst_n),
        .ALL_PWRGD (pwrgd),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Pin history: index 0 = pins seen at the previous edge, 1 = two edges ago.
    logic [NPORT-1:0] h_act [3];
    logic [NPORT-1:0] h_sp1 [3];
    logic [NPORT-1:0] h_sp2 [3];
    int               m_val [NPORT];
    int               m_run [NPORT];
    int               m_com [NPORT];
    int               m_exp [NPORT];
    logic [NPORT-1:0] m_chg;
    int               cyc;
    int               hold  [NPORT];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int speed_of(input logic s1000, input logic s100);
        case ({s1000, s100})
            2'b00:   return 3;
            2'b01:   return 2;
            2'b10:   return 1;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        for (int j = 0; j < 3; j++) begin
            h_act[j] = '1;
            h_sp1[j] = '1;
            h_sp2[j] = '1;
        end
        for (int i = 0; i < NPORT; i++) begin
            m_val[i] = 0;
            m_run[i] = 0;
            m_com[i] = 0;
            m_exp[i] = 0;
        end
        m_chg = '0;
    endtask

    task automatic model_edge();
        logic [NPORT-1:0] set;
        logic [NPORT-1:0] clr;
        int               code;
        if (!rst_n || !pwrgd) begin
            model_reset();
        end else begin
            cyc++;
            set = '0;
            for (int i = 0; i < NPORT; i++) begin
                code = speed_of(h_sp1[1][i], h_sp2[1][i]);
                if (code == m_val[i]) begin
                    if (m_run[i] < 1000) m_run[i]++;
                end else begin
                    m_val[i] = code;
                    m_run[i] = 1;
                end
                if (h_act[2][i] && !h_act[1][i] && m_com[i] != 0)
                    m_exp[i] = cyc + STRETCH_CNT;
                if (m_run[i] == DEB_CNT && code != m_com[i]) begin
                    m_com[i] = code;
                    set[i]   = 1'b1;
                    if (code == 0) m_exp[i] = 0;
                end
            end
            clr   = bus.RegWr ? bus.RegWrData : '0;
            m_chg = (m_chg & ~clr) | set;
            for (int j = 2; j > 0; j--) begin
                h_act[j] = h_act[j-1];
                h_sp1[j] = h_sp1[j-1];
                h_sp2[j] = h_sp2[j-1];
            end
            h_act[0] = bus.PActivity;
            h_sp1[0] = bus.Speed1P;
            h_sp2[0] = bus.Speed2P;
        end
    endtask

    task automatic compare(input string tag);
        logic [2*NPORT-1:0] e_ls;
        logic [NPORT-1:0]   e_act;
        logic               e_irq;
        for (int i = 0; i < NPORT; i++) begin
            e_ls[2*i +: 2] = 2'(m_com[i]);
            e_act[i]       = (cyc < m_exp[i]);
        end
`ifdef LAN_LED_STATUS_IRQ_EN
        e_irq = |m_chg;
`else
        e_irq = 1'b0;
`endif
        check({tag, "_LinkSpeed"},  32'(bus.LinkSpeed),  32'(e_ls));
        check({tag, "_ActStretch"}, 32'(bus.ActStretch), 32'(e_act));
        check({tag, "_LinkChg"},    32'(bus.LinkChg),    32'(m_chg));
        check({tag, "_LanIrq"},     32'(bus.LanIrq),     32'(e_irq));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        compare(tag);
    endtask

    initial begin
        cyc           = 0;
        bus.PActivity = '1;
        bus.Speed1P   = '0;
        bus.Speed2P   = '0;
        bus.RegWr     = 1'b0;
        bus.RegWrData = '0;
        model_reset();

        // Reset, then power-bad with pins at 00
        #12;
        compare("reset");
        rst_n = 1'b1;
        for (int n = 0; n < 3; n++) tick("pwrgd_low");

        pwrgd = 1'b1;
        for (int n = 0; n < 4; n++) tick("pg_rise");
        check("pg_ls0_edge4", 32'(bus.LinkSpeed[1:0]), 32'd0);
        tick("pg_rise");
        check("pg_ls0_edge5", 32'(bus.LinkSpeed[1:0]), 32'd3);
        check("pg_chg0_edge5", 32'(bus.LinkChg[0]), 32'd1);

        // Port 1 to no-link, clear its flag, then a 2-sample glitch
        bus.Speed1P[1] = 1'b1;
        bus.Speed2P[1] = 1'b1;
        for (int n = 0; n < 8; n++) tick("p1_drop");
        bus.RegWr     = 1'b1;
        bus.RegWrData = 2'b10;
        tick("p1_clr");
        bus.RegWr     = 1'b0;
        bus.Speed1P[1] = 1'b0;
        for (int n = 0; n < 2; n++) tick("glitch");
        bus.Speed1P[1] = 1'b1;
        for (int n = 0; n < 6; n++) tick("glitch");
        check("glitch_ls1", 32'(bus.LinkSpeed[3:2]), 32'd0);
        check("glitch_chg1", 32'(bus.LinkChg[1]), 32'd0);
        bus.Speed1P[1] = 1'b0;
        for (int n = 0; n < 4; n++) tick("p1_100m");
        check("p1_ls1_edge4", 32'(bus.LinkSpeed[3:2]), 32'd0);
        tick("p1_100m");
        check("p1_ls1_edge5", 32'(bus.LinkSpeed[3:2]), 32'd2);
        check("p1_chg1_edge5", 32'(bus.LinkChg[1]), 32'd1);

        // Randomised traffic
        for (int i = 0; i < NPORT; i++) hold[i] = 0;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NPORT; i++) begin
                if (hold[i] == 0) begin
                    bus.Speed1P[i] = 1'($urandom);
                    bus.Speed2P[i] = 1'($urandom);
                    hold[i]        = $urandom_range(1, 8);
                end else begin
                    hold[i]--;
                end
                bus.PActivity[i] = ($urandom_range(0, 3) != 0);
            end
            bus.RegWr     = ($urandom_range(0, 4) == 0);
            bus.RegWrData = NPORT'($urandom);
            pwrgd         = ($urandom_range(0, 299) != 0);
            tick("rand");
        end

        // Async reset while port 0 is stretching
        pwrgd         = 1'b1;
        bus.RegWr     = 1'b0;
        bus.PActivity = '1;
        bus.Speed1P   = '0;
        bus.Speed2P   = '0;
        for (int n = 0; n < 8; n++) tick("as_link");
        bus.PActivity[0] = 1'b0;
        tick("as_pulse");
        bus.PActivity[0] = 1'b1;
        for (int n = 0; n < 5; n++) tick("as_stretch");
        check("as_pre_act0", 32'(bus.ActStretch[0]), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("as_LinkSpeed",  32'(bus.LinkSpeed),  32'd0);
        check("as_ActStretch", 32'(bus.ActStretch), 32'd0);
        check("as_LinkChg",    32'(bus.LinkChg),    32'd0);
        check("as_LanIrq",     32'(bus.LanIrq),     32'd0);
        model_reset();
        for (int n = 0; n < 2; n++) tick("as_hold");
        rst_n = 1'b1;
        for (int n = 0; n < 6; n++) tick("as_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lan_led_status.md
Name: lan_led_status

Overview:
- Clocked status collector for the per-port Ethernet LED signals (ACT#, LINK1000#, LINK100#) that the LAN controllers drive into the CPLD.
- Reads those pins instead of driving LEDs. It synchronises and debounces them, decodes link speed, and stretches activity strobes into a steady flag.
- Records link-change events in sticky W1C bits for the BMC/host register block and raises an optional interrupt.

Parameters:
- NPORT, 2: number of LAN ports.
- DEB_CNT, 3: consecutive stable samples required before a new speed pair is committed (range 1..15).
- STRETCH_CNT, 1638: activity stretch length in CLK32768 cycles (about 50 ms). Must be at least 1.
- SCW, 11: stretch counter width. Must satisfy 2^SCW > STRETCH_CNT.

Ports:
- CLK32768  in  1  32.768 kHz free-running clock.
- RST_N  in  1  asynchronous active-low reset.
- ALL_PWRGD  in  1  all rails good. Low means the LAN pins are invalid.
- PActivity  in  NPORT  ACT# from the LAN controllers, active-low, asynchronous.
- Speed1P  in  NPORT  LINK1000# from the LAN controllers, asynchronous.
- Speed2P  in  NPORT  LINK100# from the LAN controllers, asynchronous.
- RegWr  in  1  one-cycle write strobe to the LinkChg W1C register.
- RegWrData  in  NPORT  write data. A 1 clears the corresponding LinkChg bit.
- LinkSpeed  out  2*NPORT  per-port code, port i at bits [2i+1:2i]: 00 no link, 01 10M, 10 100M, 11 1000M.
- ActStretch  out  NPORT  1 while port activity was seen within the last STRETCH_CNT cycles.
- LinkChg  out  NPORT  sticky flag: committed LinkSpeed of port i changed.
- LanIrq  out  1  level interrupt, active-high.

Behaviour:
- Reset (RST_N=0, async): all synchroniser flops go to 1. Candidate and committed pairs go to 11, debounce and stretch counters to 0. LinkSpeed=0, ActStretch=0, LinkChg=0, LanIrq=0.
- ALL_PWRGD=0 (sampled synchronously): same state as reset on every edge. Pins are ignored and writes are ignored.
- Synchronisation: 2-flop synchroniser per input bit. All logic below uses the synchronised values.
- Speed decode, {Speed1P,Speed2P}:
  - 00 gives 11 (1000M).
  - 01 gives 10 (100M).
  - 10 gives 01 (10M).
  - 11 gives 00 (no link).
- Debounce, per port:
  - If the synchronised pair differs from the candidate, load the candidate and clear the counter.
  - Else, if the candidate differs from the committed pair, increment the counter.
  - When the counter reaches DEB_CNT-1 and the pair still matches, commit the pair and clear the counter.
  - A pulse shorter than DEB_CNT samples never commits.
- Latency: a clean pin change reaches LinkSpeed DEB_CNT+2 edges after the first sampling edge (5 for DEB_CNT=3).
- Activity, per port:
  - A synchronised ACT# falling edge (previous 1, current 0) reloads the stretch counter with STRETCH_CNT, but only while committed LinkSpeed≠00. Otherwise the edge is ignored.
  - Otherwise the counter decrements while nonzero and saturates at 0.
  - ActStretch = (counter≠0), registered. It rises 3 edges after the pin falls.
  - A new edge while the counter is nonzero reloads it (retrigger).
  - If link drops to 00, clear the counter and ActStretch on the same edge as the commit.
- LinkChg, per port:
  - Set on the edge where a commit changes the committed LinkSpeed code.
  - Cleared by RegWr=1 with RegWrData[i]=1.
  - If set and clear occur on the same edge, set wins.
  - Writing 0 has no effect.
- All outputs are registered. No combinational path from inputs to outputs.

Optional Feature:
- Macro LAN_LED_STATUS_IRQ_EN.
- Defined: LanIrq is a flop loaded each edge with the OR of the next-state LinkChg. It asserts on the same edge as the first LinkChg bit and deasserts on the edge where the last bit clears. It is 0 in reset and while ALL_PWRGD=0.
- Undefined: LanIrq is tied to 0 and the interrupt flop is not built. Everything else is unchanged.

Test Plan:
- Reset and power-good: hold RST_N=0, then release with ALL_PWRGD=0 and pins at 00 -> LinkSpeed=0000, ActStretch=00, LinkChg=00, LanIrq=0. Raise ALL_PWRGD -> LinkSpeed[1:0]=11 after 5 edges and LinkChg[0]=1.
- Glitch rejection: port 1 pins go 11 to 01 for 2 cycles, then back to 11 (DEB_CNT=3) -> LinkSpeed[3:2] stays 00 and LinkChg[1]=0. Hold 01 for 3 or more cycles -> LinkSpeed[3:2]=10 at edge 5 and LinkChg[1]=1.
- Activity stretch (STRETCH_CNT=8, port 0 linked at 1000M): single ACT# low pulse -> ActStretch[0]=1 from edge 3 for exactly 8 cycles. Second pulse at cycle 5 -> high until cycle 13 after the second edge.
- No-link gating: port 0 at 00, toggle ACT# -> ActStretch[0] stays 0. Link drop while stretching -> ActStretch[0] falls on the commit edge.
- W1C collision: LinkChg=11, RegWr with RegWrData=01 on the same edge as a new port-0 commit -> LinkChg=11. Next RegWr with 11 -> LinkChg=00, and with IRQ enabled LanIrq falls on that edge.
- Async reset mid-stretch: RST_N low while the counter is 5 -> all outputs 0 immediately, without waiting for a clock.
